// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage and its IF/ID register.
package core_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, and an idle register drains when the decoder accepts.
module if_id_reg
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_inst,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_inst
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;

  // Without a new capture, a held instruction is dropped once the decoder has taken it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= NOP_INST;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM and IF/ID capture.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_fault and rejects unaligned redirect targets.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 512
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misalign_fault
`endif
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - 4);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_halted;
  logic [XLEN-1:0] r_fetch_count;

  logic w_load;
  logic w_in_range;
  logic w_capture;
  logic w_is_ebreak;

  assign imem_addr   = r_pc;
  assign w_load      = !if_id_valid || id_ready;
  assign w_in_range  = (r_pc <= LAST_PC);
  assign w_is_ebreak = (imem_inst == EBREAK_INST);
  // Any redirect, accepted or rejected, suppresses capture in that cycle.
  assign w_capture   = (r_state == RUN) && !redirect_valid && w_load && w_in_range;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;
  logic w_misaligned;

  assign w_misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign misalign_fault = r_misalign;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (w_misaligned) begin
        r_state    <= HALT;
        r_halted   <= 1'b1;
        r_misalign <= 1'b1;
      end else begin
        r_pc       <= redirect_pc;
        r_state    <= RUN;
        r_halted   <= 1'b0;
        r_misalign <= 1'b0;
      end
`else
      r_pc     <= redirect_pc;
      r_state  <= RUN;
      r_halted <= 1'b0;
`endif
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (!w_in_range) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (w_capture) begin
            r_fetch_count <= r_fetch_count + 32'd1;
            // EBREAK is delivered, but the PC parks on it.
            if (w_is_ebreak) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= r_pc + 32'd4;
            end
          end
        end
        HALT:    r_halted <= 1'b1;
        default: r_state  <= HALT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_load  (w_capture),
    .i_drain (id_ready),
    .i_pc    (r_pc),
    .i_inst  (imem_inst),
    .o_valid (if_id_valid),
    .o_pc    (if_id_pc),
    .o_inst  (if_id_inst)
  );

  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a byte-addressed combinational instruction memory.
// Define FETCH_MISALIGN_CHECK_EN to also exercise the misaligned-redirect fault.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        halted;
  logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_fault;
`endif

  logic [7:0] mem [512];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (512)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst),
    .halted         (halted),
    .fetch_count    (fetch_count)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_fault (misalign_fault)
`endif
  );

  // Byte at the address lands in bits 31:24; anything past the last word reads as all ones.
  always_comb begin
    if (imem_addr <= 32'd508)
      imem_inst = {mem[imem_addr[8:0]], mem[imem_addr[8:0] + 9'd1],
                   mem[imem_addr[8:0] + 9'd2], mem[imem_addr[8:0] + 9'd3]};
    else
      imem_inst = 32'hFFFF_FFFF;
  end

  task automatic writeWord(input int addr, input logic [31:0] word);
    mem[addr]     = word[31:24];
    mem[addr + 1] = word[23:16];
    mem[addr + 2] = word[15:8];
    mem[addr + 3] = word[7:0];
  endtask

  task automatic applyStimulus(input logic rstV, input logic readyV,
                               input logic redirV, input logic [31:0] redirPcV);
    rst            = rstV;
    id_ready       = readyV;
    redirect_valid = redirV;
    redirect_pc    = redirPcV;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " imem_addr"},   imem_addr,   32'h0);
    checkOutput({tag, " if_id_valid"}, {31'b0, if_id_valid}, 32'h0);
    checkOutput({tag, " if_id_pc"},    if_id_pc,    32'h0);
    checkOutput({tag, " if_id_inst"},  if_id_inst,  32'h0000_0013);
    checkOutput({tag, " halted"},      {31'b0, halted}, 32'h0);
    checkOutput({tag, " fetch_count"}, fetch_count, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput({tag, " misalign"},    {31'b0, misalign_fault}, 32'h0);
`endif
  endtask

  initial begin
    for (int a = 0; a < 512; a += 4) writeWord(a, 32'h0000_0013);
    writeWord(32'h00, 32'h0010_0093);
    writeWord(32'h04, 32'h0020_0113);
    writeWord(32'h08, 32'h0010_0073);
    writeWord(32'h40, 32'h0030_0193);
    writeWord(32'h44, 32'h0040_0213);

    rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    $display("[TB] starting fetch_stage directed sequence");

    applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(1, 1, 0, 32'h0);
    checkResetState("reset");

    // BOOT cycle: nothing captured yet.
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("boot valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("boot addr",  imem_addr,   32'h0);
    checkOutput("boot count", fetch_count, 32'h0);

    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("d0 valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("d0 pc",    if_id_pc,    32'h0);
    checkOutput("d0 inst",  if_id_inst,  32'h0010_0093);
    checkOutput("d0 count", fetch_count, 32'h1);
    checkOutput("d0 addr",  imem_addr,   32'h4);

    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 0, 0, 32'h0);
      checkOutput($sformatf("stall%0d if_id_pc", s), if_id_pc, 32'h0);
      checkOutput($sformatf("stall%0d addr", s),     imem_addr, 32'h4);
      checkOutput($sformatf("stall%0d count", s),    fetch_count, 32'h1);
    end

    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("d1 pc",    if_id_pc,    32'h4);
    checkOutput("d1 inst",  if_id_inst,  32'h0020_0113);
    checkOutput("d1 count", fetch_count, 32'h2);
    checkOutput("d1 addr",  imem_addr,   32'h8);

    // Stall, then redirect while the decoder is still stalled.
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("hold addr",  imem_addr,   32'h8);
    checkOutput("hold count", fetch_count, 32'h2);
    applyStimulus(0, 0, 1, 32'h40);
    checkOutput("flush valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("flush addr",  imem_addr,   32'h40);
    checkOutput("flush count", fetch_count, 32'h2);
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("d40 valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("d40 pc",    if_id_pc,    32'h40);
    checkOutput("d40 inst",  if_id_inst,  32'h0030_0193);
    checkOutput("d40 count", fetch_count, 32'h3);

    // EBREAK at 0x08 halts with the PC parked on it.
    applyStimulus(0, 1, 1, 32'h8);
    checkOutput("rd8 valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("rd8 addr",  imem_addr, 32'h8);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("ebreak valid",  {31'b0, if_id_valid}, 32'h1);
    checkOutput("ebreak pc",     if_id_pc,    32'h8);
    checkOutput("ebreak inst",   if_id_inst,  32'h0010_0073);
    checkOutput("ebreak halted", {31'b0, halted}, 32'h1);
    checkOutput("ebreak addr",   imem_addr,   32'h8);
    checkOutput("ebreak count",  fetch_count, 32'h4);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("drain valid",  {31'b0, if_id_valid}, 32'h0);
    checkOutput("drain halted", {31'b0, halted}, 32'h1);
    checkOutput("drain addr",   imem_addr,   32'h8);
    checkOutput("drain count",  fetch_count, 32'h4);
    applyStimulus(0, 1, 1, 32'h0);
    checkOutput("resume halted", {31'b0, halted}, 32'h0);
    checkOutput("resume addr",   imem_addr, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("resume pc",    if_id_pc,    32'h0);
    checkOutput("resume inst",  if_id_inst,  32'h0010_0093);
    checkOutput("resume count", fetch_count, 32'h5);

    // Run off the end of the 512-byte memory.
    applyStimulus(0, 1, 1, 32'h1F8);
    checkOutput("end rd addr",  imem_addr,   32'h1F8);
    checkOutput("end rd count", fetch_count, 32'h5);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("d1f8 pc", if_id_pc, 32'h1F8);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("d1fc pc",     if_id_pc,    32'h1FC);
    checkOutput("d1fc addr",   imem_addr,   32'h200);
    checkOutput("d1fc halted", {31'b0, halted}, 32'h0);
    checkOutput("d1fc count",  fetch_count, 32'h7);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("oor halted", {31'b0, halted}, 32'h1);
    checkOutput("oor valid",  {31'b0, if_id_valid}, 32'h0);
    checkOutput("oor pc",     if_id_pc,    32'h1FC);
    checkOutput("oor count",  fetch_count, 32'h7);
    checkOutput("oor addr",   imem_addr,   32'h200);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("oor2 count",  fetch_count, 32'h7);
    checkOutput("oor2 halted", {31'b0, halted}, 32'h1);

    // Redirect arriving while EBREAK sits on the fetch port wins.
    applyStimulus(0, 1, 1, 32'h8);
    checkOutput("pre addr",   imem_addr, 32'h8);
    checkOutput("pre halted", {31'b0, halted}, 32'h0);
    applyStimulus(0, 1, 1, 32'h40);
    checkOutput("race addr",   imem_addr,   32'h40);
    checkOutput("race valid",  {31'b0, if_id_valid}, 32'h0);
    checkOutput("race halted", {31'b0, halted}, 32'h0);
    checkOutput("race count",  fetch_count, 32'h7);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("post pc",    if_id_pc,    32'h40);
    checkOutput("post inst",  if_id_inst,  32'h0030_0193);
    checkOutput("post count", fetch_count, 32'h8);

    // Reset overrides a simultaneous redirect.
    applyStimulus(1, 1, 1, 32'h80);
    checkResetState("midreset");

    // Redirect during BOOT.
    applyStimulus(0, 1, 1, 32'h44);
    checkOutput("bootrd addr",  imem_addr,   32'h44);
    checkOutput("bootrd valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("bootrd count", fetch_count, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("d44 pc",    if_id_pc,    32'h44);
    checkOutput("d44 inst",  if_id_inst,  32'h0040_0213);
    checkOutput("d44 count", fetch_count, 32'h1);
    checkOutput("d44 addr",  imem_addr,   32'h48);

`ifdef FETCH_MISALIGN_CHECK_EN
    applyStimulus(0, 1, 1, 32'h42);
    checkOutput("mis fault",  {31'b0, misalign_fault}, 32'h1);
    checkOutput("mis halted", {31'b0, halted}, 32'h1);
    checkOutput("mis addr",   imem_addr, 32'h48);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("mis hold addr",  imem_addr,   32'h48);
    checkOutput("mis hold count", fetch_count, 32'h1);
    applyStimulus(0, 1, 1, 32'h0);
    checkOutput("mis clr fault",  {31'b0, misalign_fault}, 32'h0);
    checkOutput("mis clr halted", {31'b0, halted}, 32'h0);
    checkOutput("mis clr addr",   imem_addr, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V core.
- Owns the program counter and drives the byte address into the combinational instruction memory, which returns a 32-bit word assembled from 4 bytes (byte at PC in bits 31:24).
- Captures the returned word into the IF/ID pipeline register for the decoder.
- Handles decode back-pressure, EX-stage redirects (branch/jump) and a halt on EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 512, instruction memory size in bytes; bounds the legal fetch range.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- imem_addr  output  32  byte address to instruction memory (equals current PC)
- imem_inst  input  32  instruction word returned combinationally for imem_addr
- id_ready  input  1  decoder accepts IF/ID contents this cycle
- redirect_valid  input  1  EX requests PC change (taken branch/jump)
- redirect_pc  input  32  redirect target
- if_id_valid  output  1  IF/ID register holds a valid instruction
- if_id_pc  output  32  PC of held instruction
- if_id_inst  output  32  held instruction word
- halted  output  1  fetch stopped (EBREAK fetched or out-of-range PC)
- fetch_count  output  32  number of instructions delivered into IF/ID since reset

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_pc=0, if_id_inst=32'h0000_0013 (NOP), halted=0, fetch_count=0.
- Reset mid-operation overrides everything in the same edge, including a pending redirect.
- imem_addr = pc, combinational from the register. Memory is combinational, so the fetch latency is 1 cycle: the word for pc is captured at the next edge.
- FSM:
  - BOOT: one cycle, no capture; goes to RUN.
  - RUN: normal fetch.
  - HALT: no capture, pc frozen, halted=1.
- Load condition in RUN: load = !if_id_valid || id_ready.
- RUN, no redirect, load=1, pc in range:
  - if_id_valid<=1, if_id_pc<=pc, if_id_inst<=imem_inst.
  - pc<=pc+4, modulo 2^32.
  - fetch_count+=1.
- RUN, load=0 (stall): pc, IF/ID and fetch_count hold.
- Redirect: redirect_valid=1 in any state (BOOT, RUN or HALT) beats stall and halt:
  - pc<=redirect_pc; if_id_valid<=0 (flush); state<=RUN; halted<=0.
  - No capture that cycle and fetch_count is unchanged.
- EBREAK: in RUN with load=1 and imem_inst==32'h0010_0073:
  - The EBREAK is delivered normally and counted.
  - Then state<=HALT, halted<=1, pc not incremented.
  - IF/ID keeps draining: if_id_valid clears once id_ready=1.
- Out of range: when pc > IMEM_BYTES-4 in RUN:
  - No capture; state<=HALT; halted<=1.
  - imem_inst is ignored that cycle.
- Simultaneous redirect and EBREAK fetch: the redirect wins and the EBREAK is discarded.
- Redirect while stalled: the flush discards the held instruction even though id_ready=0.
- fetch_count wraps at 2^32.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined: adds output misalign_fault (1 bit, reset 0).
  - A redirect_pc with bits[1:0]!=0 sets misalign_fault=1, sets state to HALT, and leaves pc unchanged.
  - misalign_fault clears only on rst or on a later aligned redirect.
- Undefined: no port; the redirect target is used as-is.

Decomposition:
- Shared package core_pkg holds:
  - Constants NOP_INST=32'h0000_0013 and EBREAK_INST=32'h0010_0073.
  - Fetch-state enum {BOOT, RUN, HALT}.
  - XLEN=32.
- One natural sub-module: if_id_reg, the pipeline register with load/flush/valid. The PC/FSM logic stays in fetch_stage.

Test Plan:
- Reset release with RESET_PC=0, id_ready=1, memory holding 0x00100093 at 0 and 0x00200113 at 4 -> BOOT cycle with if_id_valid=0; next edges deliver (pc 0, 0x00100093), then (pc 4, 0x00200113); fetch_count=2.
- id_ready=0 for 3 cycles after the first delivery -> if_id_pc stays 0 and pc stays 4; once id_ready=1, pc 4 is delivered with no instruction lost or duplicated.
- redirect_valid=1, redirect_pc=0x40 while stalled -> if_id_valid=0 the next cycle; the following cycle delivers pc 0x40; fetch_count is not bumped by the flush.
- EBREAK at 0x08 -> delivered with if_id_pc=8, halted=1, pc stays 8; a redirect to 0 then clears halted and fetch resumes at 0.
- Sequential run to pc=0x200 with IMEM_BYTES=512 -> last delivered pc=0x1FC, then halted=1 and no capture at 0x200.
- With FETCH_MISALIGN_CHECK_EN defined, redirect_pc=0x42 -> misalign_fault=1, halted=1; rst asserted mid-run -> all outputs return to their reset values on the next edge.
